ifid_elastic_reg: RTL and testbench

- Parametrised, elastic successor to the fixed IF/ID pipeline register.
- Carries a {pc, instr} payload between the fetch and decode stages using valid/ready handshakes on both sides.
- A 2-entry skid buffer provides full throughput with a registered, backpressure-safe up_ready_o.
- A flush input turns the stage into a bubble, for branch/jump redirect.

---
 rtl/ifid_elastic_reg.sv | 122 ++++++++++++
 tb/tb_ifid_elastic_reg.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifid_elastic_reg.sv
// ============================================================================
// Module   : ifid_elastic_reg
// Purpose  : elastic IF/ID register with a 2-entry skid buffer and flush to bubble.
//            Optional perf counters are enabled by defining IFID_ELASTIC_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifid_elastic_reg #(
    parameter int                 PC_W         = 32,
    parameter int                 INSTR_W      = 32,
    parameter logic [INSTR_W-1:0] BUBBLE_INSTR = {INSTR_W{1'b0}}
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               up_valid_i,
    output logic               up_ready_o,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               dn_valid_o,
    input  logic               dn_ready_i,
    output logic [PC_W-1:0]    pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [1:0]         occupancy_o
`ifdef IFID_ELASTIC_PERF_EN
    ,
    output logic [31:0]        stall_cnt_o,
    output logic [31:0]        flush_cnt_o
`endif
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]         r_state;
    logic [PC_W-1:0]    r_main_pc;
    logic [INSTR_W-1:0] r_main_instr;
    logic [PC_W-1:0]    r_skid_pc;
    logic [INSTR_W-1:0] r_skid_instr;
    logic               w_up_xfer;
    logic               w_dn_xfer;

    assign dn_valid_o  = (r_state != S_EMPTY);
    assign up_ready_o  = (r_state != S_FULL);
    assign occupancy_o = r_state;
    assign w_up_xfer   = up_valid_i & up_ready_o;
    assign w_dn_xfer   = dn_valid_o & dn_ready_i;

    // Payload is masked while empty so a flushed stage always looks like a NOP.
    assign pc_o    = dn_valid_o ? r_main_pc    : {PC_W{1'b0}};
    assign instr_o = dn_valid_o ? r_main_instr : BUBBLE_INSTR;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state      <= S_EMPTY;
            r_main_pc    <= {PC_W{1'b0}};
            r_main_instr <= BUBBLE_INSTR;
            r_skid_pc    <= {PC_W{1'b0}};
            r_skid_instr <= BUBBLE_INSTR;
        end else if (flush_i) begin
            r_state <= S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_up_xfer) begin
                        r_state      <= S_BUSY;
                        r_main_pc    <= pc_i;
                        r_main_instr <= instr_i;
                    end
                end
                S_BUSY: begin
                    if (w_up_xfer && w_dn_xfer) begin
                        r_main_pc    <= pc_i;
                        r_main_instr <= instr_i;
                    end else if (w_up_xfer) begin
                        r_state      <= S_FULL;
                        r_skid_pc    <= pc_i;
                        r_skid_instr <= instr_i;
                    end else if (w_dn_xfer) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_dn_xfer) begin
                        r_state      <= S_BUSY;
                        r_main_pc    <= r_skid_pc;
                        r_main_instr <= r_skid_instr;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

`ifdef IFID_ELASTIC_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (dn_valid_o && !dn_ready_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush_i && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifid_elastic_reg.sv
// ============================================================================
// Module   : tb_ifid_elastic_reg
// Purpose  : self-checking bench for ifid_elastic_reg against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ifid_elastic_reg;

    localparam int          PC_W   = 32;
    localparam int          IW     = 32;
    localparam logic [31:0] BUBBLE = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          up_valid = 1'b0;
    logic          up_ready;
    logic [31:0]   pc = '0;
    logic [31:0]   instr = '0;
    logic          dn_valid;
    logic          dn_ready = 1'b0;
    logic [31:0]   pc_out;
    logic [31:0]   instr_out;
    logic [1:0]    occ;
`ifdef IFID_ELASTIC_PERF_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   flush_cnt;
`endif

    ifid_elastic_reg #(.PC_W(PC_W), .INSTR_W(IW), .BUBBLE_INSTR(BUBBLE)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .up_valid_i (up_valid),
        .up_ready_o (up_ready),
        .pc_i       (pc),
        .instr_i    (instr),
        .dn_valid_o (dn_valid),
        .dn_ready_i (dn_ready),
        .pc_o       (pc_out),
        .instr_o    (instr_out),
        .occupancy_o(occ)
`ifdef IFID_ELASTIC_PERF_EN
        ,
        .stall_cnt_o(stall_cnt),
        .flush_cnt_o(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] q[$];
    logic [63:0] popped;
    bit          last_up_x;
    logic [31:0] m_stall = 0;
    logic [31:0] m_flush = 0;

    // Advance one edge: model holds at most two beats in FIFO order.
    task automatic tick();
        bit up_x, dn_x;
        up_x = up_valid && (q.size() < 2);
        dn_x = dn_ready && (q.size() != 0);
        @(posedge clk);
        if (!rst) begin
            q.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (q.size() != 0 && !dn_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (flush) begin
                if (m_flush != 32'hFFFF_FFFF) m_flush++;
                q.delete();
            end else begin
                if (dn_x) popped = q.pop_front();
                if (up_x) q.push_back({pc, instr});
            end
        end
        last_up_x = up_x && rst && !flush;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 0; up_valid = 1; pc = 32'h40; instr = 32'hDEAD_BEEF; dn_ready = 0;
        tick(); tick();
        n_cmp++;
        if ({dn_valid, up_ready, occ, pc_out, instr_out} !== {1'b0, 1'b1, 2'd0, 32'h0, BUBBLE}) begin
            n_fail++;
            $display("FAIL reset: got v=%b r=%b occ=%0d pc=%h ins=%h, expected v=0 r=1 occ=0 pc=0 ins=%h",
                     dn_valid, up_ready, occ, pc_out, instr_out, BUBBLE);
        end
        up_valid = 0; rst = 1;
        tick();
    endtask

    task automatic test_streaming();
        logic [31:0] pcs [3];
        logic [31:0] ins [3];
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
        ins[0] = 32'hA; ins[1] = 32'hB; ins[2] = 32'hC;
        dn_ready = 1;
        for (int i = 0; i < 3; i++) begin
            up_valid = 1; pc = pcs[i]; instr = ins[i];
            tick();
            n_cmp++;
            if ({dn_valid, up_ready, pc_out, instr_out} !== {1'b1, 1'b1, pcs[i], ins[i]}) begin
                n_fail++;
                $display("FAIL stream[%0d]: got v=%b r=%b pc=%h ins=%h, expected v=1 r=1 pc=%h ins=%h",
                         i, dn_valid, up_ready, pc_out, instr_out, pcs[i], ins[i]);
            end
        end
        up_valid = 0;
        tick();
        n_cmp++;
        if ({dn_valid, occ} !== {1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL stream_drain: got v=%b occ=%0d, expected v=0 occ=0", dn_valid, occ);
        end
    endtask

    task automatic test_backpressure();
        dn_ready = 0;
        up_valid = 1; pc = 32'h10; instr = 32'h110; tick();
        pc = 32'h14; instr = 32'h114; tick();
        up_valid = 0;
        n_cmp++;
        if ({occ, up_ready, dn_valid, pc_out} !== {2'd2, 1'b0, 1'b1, 32'h10}) begin
            n_fail++;
            $display("FAIL bp_full: got occ=%0d r=%b v=%b pc=%h, expected occ=2 r=0 v=1 pc=10",
                     occ, up_ready, dn_valid, pc_out);
        end
        dn_ready = 1;
        tick();
        n_cmp++;
        if ({occ, dn_valid, pc_out, instr_out} !== {2'd1, 1'b1, 32'h14, 32'h114}) begin
            n_fail++;
            $display("FAIL bp_second: got occ=%0d v=%b pc=%h ins=%h, expected occ=1 v=1 pc=14 ins=114",
                     occ, dn_valid, pc_out, instr_out);
        end
        tick();
        n_cmp++;
        if ({occ, dn_valid, up_ready} !== {2'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL bp_drain: got occ=%0d v=%b r=%b, expected occ=0 v=0 r=1", occ, dn_valid, up_ready);
        end
    endtask

    task automatic test_flush_full();
        dn_ready = 0;
        up_valid = 1; pc = 32'h18; instr = 32'h1; tick();
        pc = 32'h1C; instr = 32'h2; tick();
        flush = 1; pc = 32'h20; instr = 32'h3;
        tick();
        flush = 0; up_valid = 0;
        n_cmp++;
        if ({occ, dn_valid, up_ready, pc_out, instr_out} !== {2'd0, 1'b0, 1'b1, 32'h0, BUBBLE}) begin
            n_fail++;
            $display("FAIL flush_full: got occ=%0d v=%b r=%b pc=%h ins=%h, expected occ=0 v=0 r=1 pc=0 ins=%h",
                     occ, dn_valid, up_ready, pc_out, instr_out, BUBBLE);
        end
        dn_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (dn_valid !== 1'b0 || pc_out === 32'h20) begin
                n_fail++;
                $display("FAIL flush_drop[%0d]: got v=%b pc=%h, expected v=0 pc=0", i, dn_valid, pc_out);
            end
        end
    endtask

    task automatic test_mid_reset();
        dn_ready = 0;
        up_valid = 1; pc = 32'h30; instr = 32'h330; tick();
        up_valid = 0;
        n_cmp++;
        if ({occ, pc_out} !== {2'd1, 32'h30}) begin
            n_fail++;
            $display("FAIL midrst_busy: got occ=%0d pc=%h, expected occ=1 pc=30", occ, pc_out);
        end
        rst = 0; flush = 1;
        tick();
        rst = 1; flush = 0;
        n_cmp++;
        if ({occ, dn_valid, up_ready, pc_out, instr_out} !== {2'd0, 1'b0, 1'b1, 32'h0, BUBBLE}) begin
            n_fail++;
            $display("FAIL midrst: got occ=%0d v=%b r=%b pc=%h ins=%h, expected occ=0 v=0 r=1 pc=0 ins=%h",
                     occ, dn_valid, up_ready, pc_out, instr_out, BUBBLE);
        end
`ifdef IFID_ELASTIC_PERF_EN
        n_cmp++;
        if (flush_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_flushcnt: got %0d, expected 0", flush_cnt);
        end
`endif
    endtask

`ifdef IFID_ELASTIC_PERF_EN
    task automatic test_perf();
        rst = 0; tick(); rst = 1;
        dn_ready = 0; up_valid = 1; pc = 32'h50; instr = 32'h5; tick();
        up_valid = 0;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (stall_cnt !== 32'd5) begin
            n_fail++;
            $display("FAIL perf_stall: got %0d, expected 5", stall_cnt);
        end
        dn_ready = 1; flush = 1; tick(); tick(); flush = 0;
        n_cmp++;
        if (flush_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_flush: got %0d, expected 2", flush_cnt);
        end
    endtask
`endif

    task automatic test_random();
        logic [67:0] got, exp;
        up_valid = 0;
        for (int i = 0; i < 400; i++) begin
            // The sender holds an unaccepted offer stable until it transfers.
            if (!(up_valid && !last_up_x)) begin
                up_valid = ($urandom_range(0, 3) != 0);
                pc       = $urandom;
                instr    = $urandom;
            end
            dn_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 24) == 0);
            tick();
            exp = {q.size() != 0, q.size() < 2, 2'(q.size()),
                   (q.size() != 0) ? q[0][63:32] : 32'h0,
                   (q.size() != 0) ? q[0][31:0]  : BUBBLE};
            got = {dn_valid, up_ready, occ, pc_out, instr_out};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: got v/r/occ/pc/ins=%h, expected %h", i, got, exp);
            end
`ifdef IFID_ELASTIC_PERF_EN
            n_cmp++;
            if ({stall_cnt, flush_cnt} !== {m_stall, m_flush}) begin
                n_fail++;
                $display("FAIL random_perf[%0d]: got stall=%0d flush=%0d, expected stall=%0d flush=%0d",
                         i, stall_cnt, flush_cnt, m_stall, m_flush);
            end
`endif
        end
        flush = 0; up_valid = 0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_mid_reset();
`ifdef IFID_ELASTIC_PERF_EN
        test_perf();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
